// File: rtl/risc_v_hs_pkg.sv
// Shared types and constants for the handshake-based multi-cycle RV32I core.
package risc_v_hs_pkg;

    // Sequencer states; EXECUTE is always a single cycle.
    typedef enum logic [2:0] {
        FETCH,
        FETCH_WAIT,
        EXECUTE,
        MEM,
        MEM_WAIT,
        HALT
    } hs_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_MISALIGN = 2'd2,
        TRAP_SYSTEM   = 2'd3
    } trap_cause_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Instruction fetches are always full-word reads.
    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/risc_v_hs_mem_misalign_check.sv
// Flags a misaligned load/store address or a misaligned taken jump/branch target.
module risc_v_hs_mem_misalign_check
    import risc_v_hs_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [1:0] i_addr_lo,
    input  logic [1:0] i_target_lo,
    input  logic       i_is_ls,
    input  logic       i_is_jump,
    output logic       o_misaligned
);

    logic w_ls_mis;
    logic w_jump_mis;

    // Alignment requirement depends on the access size encoded in funct3.
    always_comb begin
        w_ls_mis = 1'b0;
        if (i_is_ls) begin
            case (i_funct3)
                3'b001, 3'b101: w_ls_mis = i_addr_lo[0];
                3'b010:         w_ls_mis = |i_addr_lo;
                default:        w_ls_mis = 1'b0;
            endcase
        end
    end

    assign w_jump_mis   = i_is_jump & (|i_target_lo);
    assign o_misaligned = w_ls_mis | w_jump_mis;

endmodule

// File: rtl/risc_v_hs.sv
// Multi-cycle RV32I core: sequencer plus datapath glue over a valid/ready memory channel.
module risc_v_hs
    import risc_v_hs_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter int unsigned RETIRE_W         = 32,
    parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    output logic                o_req_valid,
    input  logic                i_req_ready,
    output logic                o_req_we,
    output logic [31:0]         o_req_addr,
    output logic [31:0]         o_req_wdata,
    output logic [2:0]          o_req_funct3,
    input  logic                i_rsp_valid,
    input  logic [31:0]         i_rsp_rdata,
    output logic                o_halted,
    output logic [1:0]          o_trap_cause,
    output logic [RETIRE_W-1:0] o_retired,
    output logic [31:0]         o_pc_out
);

    hs_state_t             r_state;
    hs_state_t             w_state_next;
    logic [31:0]           r_pc;
    logic [31:0]           r_instr;
    logic [RETIRE_W-1:0]   r_retired;
    trap_cause_t           r_trap;
    logic [31:0]           r_rf [0:31];

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic        w_funct7_b5;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_imm_ext;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_result;
    logic [31:0] w_result;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic [31:0] w_ls_addr;
    logic        w_is_ls;
    logic        w_is_store;
    logic        w_is_jump;
    logic        w_br_taken;
    logic        w_legal;
    logic        w_writes_rd;
    logic        w_misaligned;
    trap_cause_t w_trap_cause;
    logic        w_rf_we;
    logic [31:0] w_rf_wdata;

    assign w_opcode    = r_instr[6:0];
    assign w_rd        = r_instr[11:7];
    assign w_funct3    = r_instr[14:12];
    assign w_rs1       = r_instr[19:15];
    assign w_rs2       = r_instr[24:20];
    assign w_funct7_b5 = r_instr[30];

    // x0 is never written, so it is forced to read zero here.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

    assign w_imm_i = {{20{r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                      r_instr[11:8], 1'b0};
    assign w_imm_u = {r_instr[31:12], 12'd0};
    assign w_imm_j = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                      r_instr[30:21], 1'b0};

    assign w_is_store = (w_opcode == OP_STORE);
    assign w_is_ls    = (w_opcode == OP_LOAD) | w_is_store;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_ls_addr  = w_rs1_val + w_imm_ext;
    assign w_alu_b    = (w_opcode == OP_OP) ? w_rs2_val : w_imm_ext;

    // Immediate selection and opcode legality/write-back decode.
    always_comb begin
        w_imm_ext   = w_imm_i;
        w_legal     = 1'b1;
        w_writes_rd = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC:   begin w_imm_ext = w_imm_u; w_writes_rd = 1'b1; end
            OP_JAL:             begin w_imm_ext = w_imm_j; w_writes_rd = 1'b1; end
            OP_JALR, OP_IMM,
            OP_OP:              w_writes_rd = 1'b1;
            OP_BRANCH:          w_imm_ext = w_imm_b;
            OP_STORE:           w_imm_ext = w_imm_s;
            OP_LOAD, OP_SYSTEM: w_imm_ext = w_imm_i;
            default:            w_legal   = 1'b0;
        endcase
    end

    // Integer ALU shared by OP and OP_IMM; funct7[5] selects SUB/SRA.
    always_comb begin
        w_alu_result = 32'd0;
        case (w_funct3)
            3'b000: w_alu_result = ((w_opcode == OP_OP) && w_funct7_b5) ?
                                   w_rs1_val - w_alu_b : w_rs1_val + w_alu_b;
            3'b001: w_alu_result = w_rs1_val << w_alu_b[4:0];
            3'b010: w_alu_result = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011: w_alu_result = {31'd0, w_rs1_val < w_alu_b};
            3'b100: w_alu_result = w_rs1_val ^ w_alu_b;
            3'b101: w_alu_result = w_funct7_b5 ?
                                   32'($signed(w_rs1_val) >>> w_alu_b[4:0]) :
                                   w_rs1_val >> w_alu_b[4:0];
            3'b110: w_alu_result = w_rs1_val | w_alu_b;
            default: w_alu_result = w_rs1_val & w_alu_b;
        endcase
    end

    // Branch condition evaluation.
    always_comb begin
        case (w_funct3)
            3'b000:  w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001:  w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100:  w_br_taken = ($signed(w_rs1_val) < $signed(w_rs2_val));
            3'b101:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_br_taken = (w_rs1_val < w_rs2_val);
            3'b111:  w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    // Next PC; w_is_jump marks a redirect whose target must be aligned.
    always_comb begin
        w_pc_next = w_pc_plus4;
        w_is_jump = 1'b0;
        case (w_opcode)
            OP_JAL: begin
                w_pc_next = r_pc + w_imm_j;
                w_is_jump = 1'b1;
            end
            OP_JALR: begin
                w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
                w_is_jump = 1'b1;
            end
            OP_BRANCH: begin
                if (w_br_taken) begin
                    w_pc_next = r_pc + w_imm_b;
                    w_is_jump = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Write-back value for non-memory instructions.
    always_comb begin
        case (w_opcode)
            OP_LUI:           w_result = w_imm_u;
            OP_AUIPC:         w_result = r_pc + w_imm_u;
            OP_JAL, OP_JALR:  w_result = w_pc_plus4;
            default:          w_result = w_alu_result;
        endcase
    end

    risc_v_hs_mem_misalign_check u_misalign (
        .i_funct3     (w_funct3),
        .i_addr_lo    (w_ls_addr[1:0]),
        .i_target_lo  (w_pc_next[1:0]),
        .i_is_ls      (w_is_ls),
        .i_is_jump    (w_is_jump),
        .o_misaligned (w_misaligned)
    );

    // Trap priority: illegal opcode, then SYSTEM, then misalignment.
    always_comb begin
        w_trap_cause = TRAP_NONE;
        if (!w_legal) begin
            w_trap_cause = TRAP_ILLEGAL;
        end else if (w_opcode == OP_SYSTEM) begin
            w_trap_cause = TRAP_SYSTEM;
        end else if (TRAP_ON_MISALIGN && w_misaligned) begin
            w_trap_cause = TRAP_MISALIGN;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:      if (i_req_ready) w_state_next = FETCH_WAIT;
            FETCH_WAIT: if (i_rsp_valid) w_state_next = EXECUTE;
            EXECUTE: begin
                if (w_trap_cause != TRAP_NONE) begin
                    w_state_next = HALT;
                end else if (w_is_ls) begin
                    w_state_next = MEM;
                end else begin
                    w_state_next = FETCH;
                end
            end
            MEM:        if (i_req_ready) w_state_next = MEM_WAIT;
            MEM_WAIT:   if (i_rsp_valid) w_state_next = FETCH;
            HALT:       w_state_next = HALT;
            default:    w_state_next = FETCH;
        endcase
    end

    // Memory request and status outputs decoded from the current state.
    always_comb begin
        o_req_valid  = 1'b0;
        o_req_we     = 1'b0;
        o_req_addr   = r_pc;
        o_req_wdata  = w_rs2_val;
        o_req_funct3 = FETCH_FUNCT3;
        o_halted     = 1'b0;
        case (r_state)
            FETCH: o_req_valid = 1'b1;
            MEM: begin
                o_req_valid  = 1'b1;
                o_req_we     = w_is_store;
                o_req_addr   = w_ls_addr;
                o_req_funct3 = w_funct3;
            end
            HALT:    o_halted = 1'b1;
            default: ;
        endcase
    end

    // PC, instruction latch, retire counter and trap cause.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_retired <= '0;
            r_trap    <= TRAP_NONE;
        end else begin
            case (r_state)
                FETCH_WAIT: if (i_rsp_valid) r_instr <= i_rsp_rdata;
                EXECUTE: begin
                    if (w_state_next == HALT) begin
                        r_trap <= w_trap_cause;
                    end else if (w_state_next == FETCH) begin
                        r_pc      <= w_pc_next;
                        r_retired <= r_retired + RETIRE_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (i_rsp_valid) begin
                        r_pc      <= w_pc_plus4;
                        r_retired <= r_retired + RETIRE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Register writes happen only in the retiring cycle.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_wdata = w_result;
        if (r_state == EXECUTE && w_state_next == FETCH) begin
            w_rf_we = w_writes_rd;
        end else if (r_state == MEM_WAIT && i_rsp_valid && !w_is_store) begin
            w_rf_we    = 1'b1;
            w_rf_wdata = i_rsp_rdata;
        end
    end

    // Register file storage; a reset cycle suppresses any pending write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_rf_we && (w_rd != 5'd0)) begin
            r_rf[w_rd] <= w_rf_wdata;
        end
    end

    assign o_trap_cause = r_trap;
    assign o_retired    = r_retired;
    assign o_pc_out     = r_pc;

endmodule
